// File: rtl/sram_responder_if.sv
// Pin-level bundle between a memory controller (master) and the SRAM device model (slave).
// The data bus is a shared wire; each side drives it only through its own tristate.
interface sram_responder_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic              ram_en_in;
   logic              ram_oe_in;
   logic              ram_we_in;
   logic [ADDR_W-1:0] ram_address_in;
   wire  [DATA_W-1:0] ram_data_inout;

   modport master (
      output ram_en_in,
      output ram_oe_in,
      output ram_we_in,
      output ram_address_in,
      inout  ram_data_inout
   );

   modport slave (
      input  ram_en_in,
      input  ram_oe_in,
      input  ram_we_in,
      input  ram_address_in,
      inout  ram_data_inout
   );
endinterface

// File: rtl/sram_responder.sv
// Clocked stand-in for the board's asynchronous SRAM: samples the controller pins, commits writes
// and answers reads after READ_LAT edges. Define SRAM_PROTO_CHECK_EN to build the sticky conflict detector.
module sram_responder #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int READ_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_responder_if.slave       bus,
   output logic                  busy_out,
   output logic [15:0]           rd_count_out,
   output logic [15:0]           wr_count_out,
   output logic                  conflict_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   localparam int         WORDS      = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_RELOAD = 4'(READ_LAT - 1);

   state_t                state;
   logic                  en_q, oe_q, we_q;
   logic [ADDR_W-1:0]     addr_q, addr_prev;
   logic [DATA_W-1:0]     data_q;
   logic [3:0]            cnt;
   logic                  drive_en;
   logic                  buf_valid;
   logic [DEPTH_LOG2-1:0] buf_addr;
   logic [DATA_W-1:0]     buf_data;
   logic [DATA_W-1:0]     rd_data;
   logic [DATA_W-1:0]     mem [0:WORDS-1];

   logic rd_cond, wr_cond, addr_changed, load_rd, commit;

   // Every FSM decision is made on the registered pin values, never on the raw pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q      <= 1'b1;
         oe_q      <= 1'b1;
         we_q      <= 1'b1;
         addr_q    <= '0;
         addr_prev <= '0;
         data_q    <= '0;
      end else begin
         en_q      <= bus.ram_en_in;
         oe_q      <= bus.ram_oe_in;
         we_q      <= bus.ram_we_in;
         addr_q    <= bus.ram_address_in;
         addr_prev <= addr_q;
         data_q    <= bus.ram_data_inout;
      end
   end

   assign wr_cond      = !en_q && !we_q;
   assign rd_cond      = !en_q && !oe_q && we_q;
   assign addr_changed = (addr_q != addr_prev);
   assign load_rd      = (state == READ) && rd_cond && !addr_changed && (cnt == 4'd0);
   assign commit       = (state == WRITE) && !wr_cond && buf_valid;
   assign busy_out     = (state != IDLE);

   // Write-wins arbitration: a pin pattern that is both read and write is treated as a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         drive_en     <= 1'b0;
         rd_count_out <= 16'd0;
         wr_count_out <= 16'd0;
         buf_valid    <= 1'b0;
         buf_addr     <= '0;
         buf_data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_cond) begin
                  state     <= WRITE;
                  buf_valid <= 1'b1;
                  buf_addr  <= addr_q[DEPTH_LOG2-1:0];
                  buf_data  <= data_q;
               end else if (rd_cond) begin
                  state <= READ;
                  cnt   <= CNT_RELOAD;
               end
            end
            READ: begin
               if (!rd_cond) begin
                  drive_en <= 1'b0;
                  if (wr_cond) begin
                     state     <= WRITE;
                     buf_valid <= 1'b1;
                     buf_addr  <= addr_q[DEPTH_LOG2-1:0];
                     buf_data  <= data_q;
                  end else begin
                     state <= IDLE;
                  end
               end else if (addr_changed) begin
                  cnt      <= CNT_RELOAD;
                  drive_en <= 1'b0;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  drive_en <= 1'b1;
                  if (!drive_en)
                     rd_count_out <= rd_count_out + 16'd1;
               end
            end
            WRITE: begin
               if (wr_cond) begin
                  buf_valid <= 1'b1;
                  buf_addr  <= addr_q[DEPTH_LOG2-1:0];
                  buf_data  <= data_q;
               end else begin
                  if (buf_valid)
                     wr_count_out <= wr_count_out + 16'd1;
                  buf_valid <= 1'b0;
                  if (rd_cond) begin
                     state    <= READ;
                     cnt      <= CNT_RELOAD;
                     drive_en <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array and read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (commit)
         mem[buf_addr] <= buf_data;
      if (load_rd)
         rd_data <= mem[addr_q[DEPTH_LOG2-1:0]];
   end

   // Raw-pin gating keeps us off the bus the instant the controller takes it back.
   assign bus.ram_data_inout = (drive_en && !bus.ram_oe_in && bus.ram_we_in && !bus.ram_en_in)
                               ? rd_data : 'z;

`ifdef SRAM_PROTO_CHECK_EN
   logic we_prev;
   logic conflict;

   // Flags simultaneous OE/WE assertion and an address that moves during a held write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_prev  <= 1'b1;
         conflict <= 1'b0;
      end else begin
         we_prev <= we_q;
         if ((!en_q && !oe_q && !we_q) || (!we_q && !we_prev && addr_changed))
            conflict <= 1'b1;
      end
   end

   assign conflict_out = conflict;
`else
   assign conflict_out = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a vector table for write/read/address-change timing,
// plus hand sequences for aliasing, reset mid-write and the conflict pattern.
module tb_sram_responder;

   localparam int ADDR_W   = 18;
   localparam int DATA_W   = 16;
   localparam int READ_LAT = 2;

   typedef struct {
      logic              en, oe, we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              drive;
      int                bus_mode;
      logic [DATA_W-1:0] exp_bus;
      logic              exp_busy;
      logic [15:0]       exp_rd;
      logic [15:0]       exp_wr;
   } vec_t;

   logic              clk;
   logic              rst;
   logic              tb_drive;
   logic [DATA_W-1:0] tb_data;
   logic              busy;
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
   logic              conflict;
   int                checks;
   int                errors;
   vec_t              vecs [20];

   sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

   assign sif.ram_data_inout = tb_drive ? tb_data : 'z;

   sram_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(10), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(sif.slave),
      .busy_out(busy),
      .rd_count_out(rd_count),
      .wr_count_out(wr_count),
      .conflict_out(conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic en, input logic oe, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                 input logic drive);
      sif.ram_en_in      = en;
      sif.ram_oe_in      = oe;
      sif.ram_we_in      = we;
      sif.ram_address_in = addr;
      tb_data            = data;
      tb_drive           = drive;
   endtask

   task automatic idle_pins();
      apply_stimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0);
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic check_released(input string name, input logic [DATA_W-1:0] actual, input logic [DATA_W-1:0] stale);
      checks++;
      if (actual === stale) begin
         errors++;
         $display("[TB] FAIL %s: bus shows %h, expected bus released (not %h)", name, actual, stale);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      apply_stimulus(1'b0, 1'b1, 1'b0, addr, data, 1'b1);
      repeat (2) step();
      idle_pins();
      repeat (2) step();
   endtask

   task automatic do_read(input string name, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expected);
      apply_stimulus(1'b0, 1'b0, 1'b1, addr, '0, 1'b0);
      repeat (READ_LAT + 1) step();
      check_released({name, "_early"}, sif.ram_data_inout, expected);
      step();
      check_output(name, 32'(sif.ram_data_inout), 32'(expected));
      idle_pins();
      repeat (2) step();
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // bus_mode: 0 = skip bus, 1 = bus must equal exp_bus, 2 = bus must not show exp_bus
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 18'h5, 16'h1234, 1'b1, 0, 16'h0,    1'b0, 16'd0, 16'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 18'h5, 16'h1234, 1'b1, 0, 16'h0,    1'b1, 16'd0, 16'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 18'h0, 16'h0,    1'b0, 2, 16'h1234, 1'b1, 16'd0, 16'd0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 18'h0, 16'h0,    1'b0, 2, 16'h1234, 1'b0, 16'd0, 16'd1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 18'h6, 16'hBEEF, 1'b1, 0, 16'h0,    1'b0, 16'd0, 16'd1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 18'h6, 16'hBEEF, 1'b1, 0, 16'h0,    1'b1, 16'd0, 16'd1};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 18'h0, 16'h0,    1'b0, 2, 16'hBEEF, 1'b1, 16'd0, 16'd1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 18'h0, 16'h0,    1'b0, 2, 16'hBEEF, 1'b0, 16'd0, 16'd2};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 18'h5, 16'h0,    1'b0, 2, 16'h1234, 1'b0, 16'd0, 16'd2};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 18'h5, 16'h0,    1'b0, 2, 16'h1234, 1'b1, 16'd0, 16'd2};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 18'h5, 16'h0,    1'b0, 2, 16'h1234, 1'b1, 16'd0, 16'd2};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 18'h5, 16'h0,    1'b0, 1, 16'h1234, 1'b1, 16'd1, 16'd2};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 18'h5, 16'h0,    1'b0, 1, 16'h1234, 1'b1, 16'd1, 16'd2};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 18'h6, 16'h0,    1'b0, 0, 16'h0,    1'b1, 16'd1, 16'd2};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 18'h6, 16'h0,    1'b0, 2, 16'h1234, 1'b1, 16'd1, 16'd2};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 18'h6, 16'h0,    1'b0, 2, 16'hBEEF, 1'b1, 16'd1, 16'd2};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 18'h6, 16'h0,    1'b0, 1, 16'hBEEF, 1'b1, 16'd2, 16'd2};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 18'h6, 16'h0,    1'b0, 1, 16'hBEEF, 1'b1, 16'd2, 16'd2};
      vecs[18] = '{1'b1, 1'b1, 1'b1, 18'h0, 16'h0,    1'b0, 2, 16'hBEEF, 1'b1, 16'd2, 16'd2};
      vecs[19] = '{1'b1, 1'b1, 1'b1, 18'h0, 16'h0,    1'b0, 2, 16'hBEEF, 1'b0, 16'd2, 16'd2};

      // Reset with random pins
      rst = 1'b0;
      apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), 18'($urandom), 16'($urandom), 1'b0);
      repeat (3) step();
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_rd_count", 32'(rd_count), 32'd0);
      check_output("reset_wr_count", 32'(wr_count), 32'd0);
      check_output("reset_conflict", 32'(conflict), 32'd0);
      idle_pins();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) step();

      // Write 5/6, read 5, switch to 6 mid-read
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(vecs[i].en, vecs[i].oe, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].drive);
         step();
         if (vecs[i].bus_mode == 1)
            check_output($sformatf("vec%0d_bus", i), 32'(sif.ram_data_inout), 32'(vecs[i].exp_bus));
         else if (vecs[i].bus_mode == 2)
            check_released($sformatf("vec%0d_bus", i), sif.ram_data_inout, vecs[i].exp_bus);
         check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check_output($sformatf("vec%0d_rd_count", i), 32'(rd_count), 32'(vecs[i].exp_rd));
         check_output($sformatf("vec%0d_wr_count", i), 32'(wr_count), 32'(vecs[i].exp_wr));
      end

      // Aliasing: 0x400 lands on word 0
      do_write(18'h00400, 16'hA5A5);
      check_output("alias_wr_count", 32'(wr_count), 32'd3);
      do_read("alias_read", 18'h00000, 16'hA5A5);
      check_output("alias_rd_count", 32'(rd_count), 32'd3);
      check_output("pre_conflict_flag", 32'(conflict), 32'd0);

      // Reset in the middle of a write discards the buffered data
      do_write(18'h00007, 16'h1111);
      check_output("w7_wr_count", 32'(wr_count), 32'd4);
      apply_stimulus(1'b0, 1'b1, 1'b0, 18'h00007, 16'h2222, 1'b1);
      repeat (2) step();
      check_output("midwrite_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check_output("midwrite_reset_busy", 32'(busy), 32'd0);
      check_output("midwrite_reset_wr_count", 32'(wr_count), 32'd0);
      idle_pins();
      repeat (2) step();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) step();
      do_read("midwrite_read", 18'h00007, 16'h1111);
      check_output("midwrite_wr_count", 32'(wr_count), 32'd0);
      check_output("midwrite_rd_count", 32'(rd_count), 32'd1);

      // OE and WE both low: write wins, conflict flag only in checked builds
      apply_stimulus(1'b0, 1'b0, 1'b0, 18'h00009, 16'h3C3C, 1'b1);
      repeat (2) step();
      check_output("conflict_busy", 32'(busy), 32'd1);
      idle_pins();
      repeat (2) step();
      check_output("conflict_wr_count", 32'(wr_count), 32'd1);
`ifdef SRAM_PROTO_CHECK_EN
      check_output("conflict_flag", 32'(conflict), 32'd1);
`else
      check_output("conflict_flag", 32'(conflict), 32'd0);
`endif
      do_read("conflict_read", 18'h00009, 16'h3C3C);
      check_output("conflict_rd_count", 32'(rd_count), 32'd2);
`ifdef SRAM_PROTO_CHECK_EN
      check_output("conflict_sticky", 32'(conflict), 32'd1);
`else
      check_output("conflict_sticky", 32'(conflict), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
